// File: rtl/seat_status_reader_if.sv
// Query, record-memory and response channels of the seat status reader.
interface seat_status_reader_if;
  localparam int unsigned SEAT_W = 5;
  localparam int unsigned TIME_W = 11;

  logic              q_valid;
  logic              q_ready;
  logic              q_sweep;
  logic [SEAT_W-1:0] q_seat;

  logic              mem_rd_en;
  logic [SEAT_W-1:0] mem_rd_addr;
  logic [31:0]       mem_student;
  logic [1:0]        mem_state;
  logic [TIME_W-1:0] mem_start;
  logic [TIME_W-1:0] mem_limit;
  logic [1:0]        mem_ban;

  logic              r_valid;
  logic              r_ready;
  logic [SEAT_W-1:0] r_seat;
  logic [31:0]       r_student;
  logic [1:0]        r_state;
  logic [TIME_W-1:0] r_remaining;
  logic              r_expired;
  logic              r_banned;
  logic              r_last;

  // Requester / memory / consumer side
  modport master (
    output q_valid, q_sweep, q_seat,
    input  q_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_student, mem_state, mem_start, mem_limit, mem_ban,
    input  r_valid, r_seat, r_student, r_state, r_remaining, r_expired, r_banned, r_last,
    output r_ready
  );

  // Reader side
  modport slave (
    input  q_valid, q_sweep, q_seat,
    output q_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_student, mem_state, mem_start, mem_limit, mem_ban,
    output r_valid, r_seat, r_student, r_state, r_remaining, r_expired, r_banned, r_last,
    input  r_ready
  );
endinterface

// File: rtl/seat_status_reader.sv
// Seat status reader: single-seat queries and expiry sweeps over the seat record memory.
module seat_status_reader #(
  parameter int unsigned SEATS   = 32,
  parameter int unsigned DAY_MIN = 1440
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            now_min,
  seat_status_reader_if.slave    bus,
  output logic                   busy
);
  localparam int unsigned SEAT_W = $clog2(SEATS);
  localparam int unsigned TIME_W = 11;
  localparam int unsigned CALC_W = 12;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_OCC   = 2'b01;
  localparam logic [1:0] ST_AWAY  = 2'b10;
  localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(SEATS - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, RESP, SCAN_NEXT} state_t;

  typedef struct packed {
    logic [SEAT_W-1:0] seat;
    logic [31:0]       student;
    logic [1:0]        state;
    logic [TIME_W-1:0] remaining;
    logic              expired;
    logic              banned;
    logic              last;
  } resp_t;

  state_t            state_q, state_d;
  logic [SEAT_W-1:0] addr_q, addr_d;
  logic              sweep_q, sweep_d;
  logic              final_q, final_d;
  logic              pend_v_q, pend_v_d;
  resp_t             pend_q, pend_d;
  resp_t             r_q, r_d;
  logic              q_ready_q, rd_en_q, r_valid_q;

  logic [31:0]       cap_student;
  logic [1:0]        cap_state;
  logic [TIME_W-1:0] cap_start;
  logic [TIME_W-1:0] cap_limit;
  logic [1:0]        cap_ban;

  logic [CALC_W-1:0] elapsed;
  logic              timed;
  logic              over;
  resp_t             calc;

  // Record capture one cycle after the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_student <= '0;
      cap_state   <= '0;
      cap_start   <= '0;
      cap_limit   <= '0;
      cap_ban     <= '0;
    end else if (state_q == WAIT) begin
      cap_student <= bus.mem_student;
      cap_state   <= bus.mem_state;
      cap_start   <= bus.mem_start;
      cap_limit   <= bus.mem_limit;
      cap_ban     <= bus.mem_ban;
    end
  end

  // Elapsed/remaining against the current minute, with day wrap
  always_comb begin
    if (now_min >= cap_start)
      elapsed = CALC_W'(now_min) - CALC_W'(cap_start);
    else
      elapsed = CALC_W'(now_min) + CALC_W'(DAY_MIN) - CALC_W'(cap_start);
    timed          = (cap_state == ST_OCC) || (cap_state == ST_AWAY);
    over           = elapsed >= CALC_W'(cap_limit);
    calc.seat      = addr_q;
    calc.student   = (cap_state == ST_EMPTY) ? 32'd0 : cap_student;
    calc.state     = cap_state;
    calc.remaining = (!timed || over) ? '0 : cap_limit - elapsed[TIME_W-1:0];
    calc.expired   = timed && over;
    calc.banned    = |cap_ban;
    calc.last      = 1'b0;
  end

  // Next-state and next-register logic; the newest expired sweep result is
  // held in pend so the final one can be flagged last once the scan ends.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sweep_d  = sweep_q;
    final_d  = final_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    r_d      = r_q;
    case (state_q)
      IDLE: begin
        if (bus.q_valid) begin
          sweep_d  = bus.q_sweep;
          addr_d   = bus.q_sweep ? '0 : bus.q_seat;
          final_d  = 1'b0;
          pend_v_d = 1'b0;
          state_d  = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: state_d = CALC;
      CALC: begin
        if (!sweep_q) begin
          r_d      = calc;
          r_d.last = 1'b1;
          final_d  = 1'b1;
          state_d  = RESP;
        end else if (calc.expired) begin
          pend_d   = calc;
          pend_v_d = 1'b1;
          if (pend_v_q) begin
            r_d      = pend_q;
            r_d.last = 1'b0;
            state_d  = RESP;
          end else begin
            state_d  = SCAN_NEXT;
          end
        end else if (addr_q == LAST_SEAT && !pend_v_q) begin
          r_d      = calc;
          r_d.last = 1'b1;
          final_d  = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = SCAN_NEXT;
        end
      end
      RESP: begin
        if (bus.r_ready) state_d = final_q ? IDLE : SCAN_NEXT;
      end
      SCAN_NEXT: begin
        if (addr_q == LAST_SEAT) begin
          if (pend_v_q) begin
            r_d      = pend_q;
            r_d.last = 1'b1;
            pend_v_d = 1'b0;
            final_d  = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          addr_d  = addr_q + SEAT_W'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sweep_q   <= 1'b0;
      final_q   <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_q    <= '0;
      r_q       <= '0;
      q_ready_q <= 1'b1;
      rd_en_q   <= 1'b0;
      r_valid_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sweep_q   <= sweep_d;
      final_q   <= final_d;
      pend_v_q  <= pend_v_d;
      pend_q    <= pend_d;
      r_q       <= r_d;
      q_ready_q <= (state_d == IDLE);
      rd_en_q   <= (state_d == READ);
      r_valid_q <= (state_d == RESP);
      busy      <= (state_d != IDLE);
    end
  end

  assign bus.q_ready     = q_ready_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.r_valid     = r_valid_q;
  assign bus.r_seat      = r_q.seat;
  assign bus.r_student   = r_q.student;
  assign bus.r_state     = r_q.state;
  assign bus.r_remaining = r_q.remaining;
  assign bus.r_expired   = r_q.expired;
  assign bus.r_banned    = r_q.banned;
  assign bus.r_last      = r_q.last;
endmodule

// File: doc/seat_status_reader.md
Name: seat_status_reader

Overview:
Read-side companion to the seat record memory. It answers single-seat status queries and runs full sweeps that report every seat whose occupancy time limit has expired. It reads records through a 1-cycle-latency synchronous read port and computes elapsed and remaining minutes against the system minute counter. Results go out on a valid/ready response channel to the display/release logic.

Parameters:
SEATS, 32, number of seat records; address width is clog2(SEATS)=5
DAY_MIN, 1440, minute-counter modulus; the time value ranges 0..DAY_MIN-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
now_min  in  11  current minute from the system timer, 0..1439
q_valid  in  1  query request valid
q_ready  out  1  query request accepted when q_valid and q_ready are both high
q_sweep  in  1  with q_valid: 1 = sweep all seats, 0 = single-seat query
q_seat  in  5  seat number for a single-seat query
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  5  memory read address
mem_student  in  32  record student number, valid 1 cycle after mem_rd_en
mem_state  in  2  record state: 00 EMPTY, 01 OCCUPIED, 10 AWAY, 11 RESERVED
mem_start  in  11  record start minute
mem_limit  in  11  record time limit in minutes
mem_ban  in  2  record ban level; nonzero means banned
r_valid  out  1  response valid
r_ready  in  1  response accepted
r_seat  out  5  seat number
r_student  out  32  student number; forced to 0 when the state is EMPTY
r_state  out  2  seat state
r_remaining  out  11  minutes left, saturated at 0
r_expired  out  1  limit reached
r_banned  out  1  ban nonzero
r_last  out  1  final response of the transaction
busy  out  1  transaction in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. During reset, all outputs are 0 except q_ready=1. The FSM goes to IDLE and the sweep index goes to 0.
- FSM states: IDLE, READ, WAIT, CALC, RESP, SCAN_NEXT.
  - IDLE: q_ready=1. On q_valid, latch q_sweep and q_seat (index=0 for a sweep), then go to READ. q_ready=0 in every other state.
  - READ: mem_rd_en=1 for one cycle with mem_rd_addr = the latched seat or the index. Go to WAIT.
  - WAIT: capture the mem_* inputs into registers. Go to CALC.
  - CALC: compute the result.
    - elapsed = now_min - start if now_min >= start, else now_min + DAY_MIN - start. Use 12-bit intermediates; the result is 11 bits.
    - remaining = 0 if elapsed >= limit, else limit - elapsed.
    - expired = (state == OCCUPIED or AWAY) and elapsed >= limit.
    - For EMPTY or RESERVED: remaining = 0 and expired = 0.
    - banned = (ban != 0).
    - Single query: go to RESP.
    - Sweep: go to RESP if expired, otherwise go to SCAN_NEXT.
  - RESP: drive r_valid=1 with all r_* fields held stable until r_ready. On the r_valid and r_ready handshake:
    - single query: go to IDLE;
    - sweep: go to SCAN_NEXT.
  - SCAN_NEXT: if index == SEATS-1, the sweep ends, otherwise increment the index and go to READ.
- Single-query latency: the request is accepted in cycle 0 and r_valid rises in cycle 4.
- r_last:
  - single query: always 1.
  - sweep: 1 only on the response for the highest expired seat at or below SEATS-1.
  - Sweep with no expired seat: emit one response with r_seat=SEATS-1, r_expired=0, r_last=1. This guarantees every sweep terminates with r_last.
  - Implementation: look ahead by pending the final response. The last real expired response is held until the scan completes, then emitted with r_last=1.
- Sweep response ordering: responses appear in ascending seat order.
- now_min sampling: sampled in CALC only. A timer change between READ and CALC is benign.
- Out-of-range inputs:
  - now_min >= DAY_MIN: treated modulo nothing. The result is unspecified but must not lock up the FSM.
  - start >= DAY_MIN: same rule as now_min.
- busy = (state != IDLE).
- Reset mid-transaction: abort immediately with no further mem_rd_en and r_valid=0.
- Backpressure: r_ready held low stalls the FSM indefinitely with outputs stable.

Test Plan:
- Reset, then a single query for seat 3: OCCUPIED, student 20231234, start 600, limit 120, now 650 -> cycle-4 r_valid, r_remaining=70, r_expired=0, r_banned=0, r_last=1.
- Day wrap on seat 7: start 1400, limit 60, now 30 -> elapsed 70, r_remaining=0, r_expired=1.
- EMPTY seat 0 with student field 0xFFFFFFFF and ban=2 -> r_student=0, r_remaining=0, r_expired=0, r_banned=1.
- Sweep with seats 2, 9, 31 expired, all others unexpired -> exactly three responses (seats 2, 9, 31) in that order, r_last=1 only on seat 31, 32 mem_rd_en pulses, then q_ready=1.
- Sweep with no expired seats -> one response, r_seat=31, r_expired=0, r_last=1.
- r_ready low for 10 cycles during RESP, then rst_n low mid-sweep -> fields stable while stalled; after reset all outputs 0, q_ready=1, and a following single query behaves normally.
